// File: rtl/fetch_align_unit.sv
// fetch_align_unit: instruction fetch sequencer for the dual-mode (MIPS/Y86)
// decode stage. It fetches aligned 32-bit words over a single-outstanding
// req/ack handshake and buffers them in a 12-byte queue. It presents a
// 48-bit window at the current byte PC: MIPS words are 4 bytes and Y86
// encodings are 1/2/5/6 bytes. Redirects flush the queue. A redirect that
// arrives while a request is in flight marks that response stale.
//
// Optional build macro: FETCH_PERF_EN adds saturating stall/redirect
// counters. When the macro is undefined, both perf outputs are tied to zero.

module fetch_align_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic        RESET_MODE = 1'b0,
    parameter int          QBYTES     = 12
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [47:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] next_inst_pc,
    output logic        mode,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_mode,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_redirects
);

    localparam int CW = $clog2(QBYTES + 1);

    // IDLE: no request in flight. WAIT: request in flight for the live stream.
    // STALE: request in flight whose response belongs to a flushed stream.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     q_q [QBYTES];
    logic [7:0]     q_d [QBYTES];
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_q, pc_d;
    logic           mode_q, mode_d;
    logic [29:0]    ptr_q, ptr_d;       // next word to fetch for the live stream
    logic [29:0]    addr_q, addr_d;     // address of the request on the bus
    logic [1:0]     discard_q, discard_d;

    logic [3:0]     head_op;
    logic [2:0]     inst_len;
    logic           consume;
    logic [2:0]     used_len;
    logic           ack_live;
    logic [CW:0]    src;
    logic [CW-1:0]  wr_idx;
    logic [CW-1:0]  count_left;
    logic [2:0]     app_n;
    logic [CW-1:0]  count_next;
    logic           room;

    // Instruction length from the head byte; MIPS is always one word.
    always_comb begin
        head_op = q_q[0][7:4];
        if (!mode_q) begin
            inst_len = 3'd4;
        end else begin
            case (head_op)
                4'h0, 4'h1, 4'h9:       inst_len = 3'd1;
                4'h2, 4'h6, 4'hA, 4'hB: inst_len = 3'd2;
                4'h7, 4'h8:             inst_len = 3'd5;
                4'h3, 4'h4, 4'h5:       inst_len = 3'd6;
                default:                inst_len = 3'd1;
            endcase
        end
    end

    // Presented window; bytes not yet in the queue read as zero.
    always_comb begin
        inst = '0;
        for (int k = 0; k < 6; k++) begin
            if ((mode_q || k < 4) && (CW'(k) < count_q)) begin
                inst[8*k +: 8] = q_q[k];
            end
        end
    end

    assign inst_valid   = (count_q >= CW'(inst_len));
    assign next_inst_pc = pc_q + 32'(inst_len);
    assign pc           = pc_q;
    assign mode         = mode_q;
    assign imem_req     = (state_q != ST_IDLE);
    assign imem_addr    = addr_q;

    // Next-state: consume, append, fetch sequencing, then redirect override.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        mode_d     = mode_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        src        = '0;
        wr_idx     = '0;
        app_n      = 3'd0;

        consume  = inst_valid && inst_ready && !redirect;
        used_len = consume ? inst_len : 3'd0;
        ack_live = imem_ack && (state_q == ST_WAIT);

        // Shift the queue down by the consumed length.
        for (int i = 0; i < QBYTES; i++) begin
            src = (CW+1)'(i) + (CW+1)'(used_len);
            if (src < (CW+1)'(QBYTES)) begin
                q_d[i] = q_q[src[CW-1:0]];
            end else begin
                q_d[i] = 8'h00;
            end
        end
        count_left = count_q - CW'(used_len);

        // Append response bytes [discard..3] behind the surviving bytes.
        if (ack_live) begin
            for (int j = 0; j < 4; j++) begin
                if (2'(j) >= discard_q) begin
                    wr_idx = count_left + CW'(j) - CW'(discard_q);
                    if (wr_idx < CW'(QBYTES)) begin
                        q_d[wr_idx] = imem_rdata[8*j +: 8];
                    end
                end
            end
            app_n     = 3'd4 - 3'(discard_q);
            discard_d = 2'b00;
            ptr_d     = ptr_q + 30'd1;
        end

        count_next = count_left + CW'(app_n);
        room       = (count_next <= CW'(QBYTES - 4));
        count_d    = count_next;

        if (consume) begin
            pc_d = pc_q + 32'(inst_len);
        end

        case (state_q)
            ST_IDLE: begin
                if (room) begin
                    state_d = ST_WAIT;
                    addr_d  = ptr_q;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (room) begin
                        addr_d = ptr_q + 30'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STALE: begin
                if (imem_ack) begin
                    if (room) begin
                        state_d = ST_WAIT;
                        addr_d  = ptr_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect wins: flush, retarget, and never retract a request in flight.
        if (redirect) begin
            count_d   = '0;
            mode_d    = redirect_mode;
            pc_d      = redirect_mode ? redirect_pc : {redirect_pc[31:2], 2'b00};
            ptr_d     = redirect_pc[31:2];
            discard_d = redirect_mode ? redirect_pc[1:0] : 2'b00;
            addr_d    = addr_q;
            if (state_q == ST_IDLE) begin
                state_d = ST_WAIT;
                addr_d  = redirect_pc[31:2];
            end else if (imem_ack) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_STALE;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pc_q      <= RESET_PC;
            mode_q    <= RESET_MODE;
            ptr_q     <= RESET_PC[31:2];
            addr_q    <= RESET_PC[31:2];
            discard_q <= RESET_MODE ? RESET_PC[1:0] : 2'b00;
            // NOTE: the byte queue is small, so it is reset as well; the bytes
            // above count are masked anyway, so this only keeps X out of sim.
            for (int i = 0; i < QBYTES; i++) begin
                q_q[i] <= 8'h00;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every flop samples its pre-edge inputs.
            state_q   <= state_d;
            count_q   <= count_d;
            pc_q      <= pc_d;
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            for (int i = 0; i < QBYTES; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_redirects_q, perf_redirects_d;

    // Saturating performance counters.
    always_comb begin
        perf_stall_d     = perf_stall_q;
        perf_redirects_d = perf_redirects_q;
        if (inst_ready && !inst_valid && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect && (perf_redirects_q != '1)) begin
            perf_redirects_d = perf_redirects_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q     <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_stall_q     <= perf_stall_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_stall     = perf_stall_q;
    assign perf_redirects = perf_redirects_q;
`else
    assign perf_stall     = 32'd0;
    assign perf_redirects = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_align_unit.sv
// Directed bench for fetch_align_unit. It uses a byte-addressed memory model
// with a programmable ack latency and logs every request address.

module tb_fetch_align_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [47:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] next_inst_pc;
    logic        mode;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        redirect_mode = 1'b0;
    logic [31:0] perf_stall;
    logic [15:0] perf_redirects;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_b [0:1023];
    int          ack_lat = 1;
    bit          busy = 1'b0;
    int          wait_cnt = 0;
    logic [29:0] lat_addr = '0;
    int          req_n = 0;
    logic [29:0] req_log [0:15];

`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd7;
    localparam logic [15:0] EXP_REDIR = 16'd2;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [15:0] EXP_REDIR = 16'd0;
`endif

    fetch_align_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .pc             (pc),
        .next_inst_pc   (next_inst_pc),
        .mode           (mode),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .redirect_mode  (redirect_mode),
        .perf_stall     (perf_stall),
        .perf_redirects (perf_redirects)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rd_word(input logic [29:0] wa);
        int base;
        base = int'(wa[7:0]) * 4;
        return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    endfunction

    // Memory responder: one request at a time, ack pulse ack_lat cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (!resetn) begin
                busy = 1'b0;
            end else if (busy) begin
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = rd_word(lat_addr);
                    busy       = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (imem_req) begin
                busy     = 1'b1;
                lat_addr = imem_addr;
                wait_cnt = ack_lat - 1;
                if (req_n < 16) req_log[req_n] = imem_addr;
                req_n++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    endtask

    task automatic set_word(input int waddr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem_b[waddr*4 + k] = w[8*k +: 8];
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        inst_ready = 1'b0;
        redirect   = 1'b0;
        tick();
        tick();
        req_n  = 0;
        resetn = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(inst_valid), 64'd1);
    endtask

    task automatic do_redirect(input logic [31:0] rpc, input logic rmode);
        redirect      = 1'b1;
        redirect_pc   = rpc;
        redirect_mode = rmode;
        tick();
        redirect      = 1'b0;
    endtask

    initial begin
        // ---- MIPS after reset, 1-cycle ack ----
        clear_mem();
        set_word(0, 32'h2001_0005);
        ack_lat = 1;
        do_reset();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_mode", 64'(mode), 64'd0);
        check("rst_perf_stall", 64'(perf_stall), 64'd0);
        check("rst_perf_redir", 64'(perf_redirects), 64'd0);
        tick();
        check("mips_req", 64'(imem_req), 64'd1);
        check("mips_addr", 64'(imem_addr), 64'd0);
        tick();
        check("mips_valid_early", 64'(inst_valid), 64'd0);
        tick();
        check("mips_valid", 64'(inst_valid), 64'd1);
        check("mips_inst", 64'(inst), 64'h0000_2001_0005);
        check("mips_next_pc", 64'(next_inst_pc), 64'd4);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("mips_pc_after", 64'(pc), 64'd4);

        // ---- Y86 stream at 0 ----
        clear_mem();
        set_word(0, 32'h000A_F230);
        set_word(1, 32'h2120_0000);
        set_word(2, 32'h0000_0010);
        ack_lat = 1;
        do_reset();
        do_redirect(32'h0, 1'b1);
        wait_valid("y86_irmov_valid", 30);
        check("y86_irmov_inst", 64'(inst), 64'h0000_000A_F230);
        check("y86_irmov_hi", 64'(inst[47:16]), 64'h0000_000A);
        check("y86_irmov_next", 64'(next_inst_pc), 64'd6);
        check("y86_mode", 64'(mode), 64'd1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("y86_rrmov_pc", 64'(pc), 64'd6);
        check("y86_rrmov_valid", 64'(inst_valid), 64'd1);
        check("y86_rrmov_lo", 64'(inst[15:0]), 64'h2120);
        check("y86_rrmov_next", 64'(next_inst_pc), 64'd8);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wait_valid("y86_nop_valid", 30);
        check("y86_nop_pc", 64'(pc), 64'd8);
        check("y86_nop_byte", 64'(inst[7:0]), 64'h10);
        check("y86_nop_next", 64'(next_inst_pc), 64'd9);

        // ---- Redirect to 0x103 Y86 with word 0 outstanding ----
        clear_mem();
        set_word(0, 32'hAAAA_AAAA);
        mem_b[32'h103] = 8'h10;
        ack_lat = 3;
        do_reset();
        tick();
        check("stale_req0", 64'(imem_addr), 64'd0);
        do_redirect(32'h0000_0103, 1'b1);
        check("stale_pc", 64'(pc), 64'h103);
        check("stale_hold_req", 64'(imem_req), 64'd1);
        check("stale_hold_addr", 64'(imem_addr), 64'd0);
        check("stale_no_valid", 64'(inst_valid), 64'd0);
        tick();
        tick();
        tick();
        check("stale_dropped", 64'(inst_valid), 64'd0);
        check("stale_new_addr", 64'(imem_addr), 64'h40);
        wait_valid("stale_valid", 20);
        check("stale_inst", 64'(inst), 64'h10);
        check("stale_pc2", 64'(pc), 64'h103);
        check("stale_next", 64'(next_inst_pc), 64'h104);
        check("stale_log1", 64'(req_log[1]), 64'h40);

        // ---- Back-pressure: queue fills, fetching stops, then resumes ----
        clear_mem();
        ack_lat = 1;
        do_reset();
        repeat (20) tick();
        check("full_req_count", 64'(req_n), 64'd3);
        check("full_req_low", 64'(imem_req), 64'd0);
        check("full_pc", 64'(pc), 64'd0);
        inst_ready = 1'b1;
        tick();
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'd3);
        check("resume_pc", 64'(pc), 64'd4);
        tick();
        inst_ready = 1'b0;
        check("resume_req_count", 64'(req_n), 64'd4);

        // ---- 5-byte call spanning a word boundary at 0x1E ----
        clear_mem();
        mem_b[32'h1C] = 8'h55;
        mem_b[32'h1D] = 8'h55;
        mem_b[32'h1E] = 8'h80;
        mem_b[32'h20] = 8'h01;
        ack_lat = 3;
        do_reset();
        do_redirect(32'h0000_001E, 1'b1);
        check("call_addr0", 64'(imem_addr), 64'd7);
        repeat (4) tick();
        check("call_partial_valid", 64'(inst_valid), 64'd0);
        check("call_partial_lo", 64'(inst[15:0]), 64'h0080);
        check("call_next", 64'(next_inst_pc), 64'h23);
        repeat (3) tick();
        check("call_wait_valid", 64'(inst_valid), 64'd0);
        tick();
        check("call_valid", 64'(inst_valid), 64'd1);
        check("call_inst", 64'(inst), 64'h0000_0001_0080);
        check("call_pc", 64'(pc), 64'h1E);

        // ---- Performance counters: 7 stall cycles, 2 redirects ----
        clear_mem();
        ack_lat = 1;
        do_reset();
        repeat (20) tick();
        ack_lat = 6;
        do_redirect(32'h0000_0040, 1'b0);
        inst_ready = 1'b1;
        repeat (7) tick();
        inst_ready = 1'b0;
        check("perf_valid", 64'(inst_valid), 64'd1);
        check("perf_stall", 64'(perf_stall), 64'(EXP_STALL));
        do_redirect(32'h0000_0080, 1'b0);
        check("perf_redirects", 64'(perf_redirects), 64'(EXP_REDIR));
        check("perf_stall_hold", 64'(perf_stall), 64'(EXP_STALL));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
